// File: rtl/mem_responder.sv
// mem_responder
//   Answers fetch/load/store requests from the multicycle CPU control FSM on
//   its unified instruction/data memory port. A request is latched, held for
//   WAIT_CYCLES wait states, then performed; ready pulses for one cycle with
//   err qualifying misaligned or out-of-range accesses (which are not done).
//
// Parameters:
//   ADDR_W      byte-address width
//   WORDS       memory depth in 32-bit words (power of two, >= 2)
//   WAIT_CYCLES wait states between request capture and response (0..15)
//
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous active-low reset
//   req    in   request strobe, held by the CPU until ready
//   we     in   1 = store, 0 = load/fetch
//   addr   in   byte address
//   wdata  in   store data
//   be     in   byte-lane write enables (only with MEM_BYTE_WRITE_EN)
//   rdata  out  load data, valid while ready=1, zero otherwise
//   ready  out  one-cycle completion pulse
//   err    out  error qualifier, valid while ready=1
//
// Build option:
//   MEM_BYTE_WRITE_EN  adds the be port; stores update only enabled lanes.
//                      Undefined: every store updates the full word.

module mem_responder #(
  parameter int ADDR_W      = 32,
  parameter int WORDS       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
`ifdef MEM_BYTE_WRITE_EN
  input  logic [3:0]        be,
`endif
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              err
);

  localparam int DATA_W = 32;
  localparam int IDX_W  = $clog2(WORDS);
  localparam int IDX_LO = 2;
  localparam int TOP_LO = IDX_LO + IDX_W;   // first address bit beyond the array
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;

  logic [ADDR_W-1:0] l_addr;
  logic              l_we;
  logic [DATA_W-1:0] l_wdata;
  logic [3:0]        l_be;

  logic [DATA_W-1:0] mem [WORDS];

  // Access operands: with zero wait states the access happens on the capture
  // edge itself, so the live inputs are used; otherwise the latched copy.
  logic [ADDR_W-1:0] a_addr;
  logic              a_we;
  logic [DATA_W-1:0] a_wdata;
  logic [3:0]        a_be;
  logic              a_bad;
  logic [IDX_W-1:0]  a_idx;
  logic              go_resp;

  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] upper;
    upper = a >> TOP_LO;
    return (a[1:0] != 2'b00) || (upper != '0);
  endfunction

  always_comb begin
    a_addr  = l_addr;
    a_we    = l_we;
    a_wdata = l_wdata;
    a_be    = l_be;
    go_resp = 1'b0;
    if (state == S_IDLE) begin
      a_addr  = addr;
      a_we    = we;
      a_wdata = wdata;
`ifdef MEM_BYTE_WRITE_EN
      a_be    = be;
`else
      a_be    = 4'hF;
`endif
      go_resp = req && (WAIT_CYCLES == 0);
    end else if (state == S_WAIT) begin
      go_resp = (cnt == 4'd1);
    end
  end

  assign a_bad = addr_bad(a_addr);
  assign a_idx = a_addr[TOP_LO-1:IDX_LO];

  // Array is not reset; a reset mid-transaction forces IDLE, so go_resp
  // never fires for the aborted request.
  always_ff @(posedge clk) begin
    if (go_resp && a_we && !a_bad) begin
      for (int i = 0; i < 4; i++) begin
        if (a_be[i]) mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      l_addr  <= '0;
      l_we    <= 1'b0;
      l_wdata <= '0;
      l_be    <= '0;
    end else begin
      // Response registers default to zero; only the edge entering RESP
      // loads them.
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
      if (go_resp) begin
        ready <= 1'b1;
        err   <= a_bad;
        if (!a_we && !a_bad) rdata <= mem[a_idx];
      end

      case (state)
        S_IDLE: begin
          if (req) begin
            l_addr  <= addr;
            l_we    <= we;
            l_wdata <= wdata;
`ifdef MEM_BYTE_WRITE_EN
            l_be    <= be;
`else
            l_be    <= 4'hF;
`endif
            cnt     <= CNT_INIT;
            state   <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  int n_cmp;
  int n_bad;

  mem_responder #(
    .ADDR_W      (32),
    .WORDS       (64),
    .WAIT_CYCLES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
`ifdef MEM_BYTE_WRITE_EN
    .be    (be),
`endif
    .rdata (rdata),
    .ready (ready),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One transaction: req raised for the capture edge only, inputs scrambled
  // afterwards. lat counts edges from capture (capture edge = 1) to the
  // first sample with ready high; -1 if ready never arrives.
  task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, output logic [31:0] rd, output logic e,
                        output int lat);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    @(posedge clk); #1;
    req = 1'b0; we = ~w; addr = 32'hFFFF_FFFF; wdata = 32'h5A5A_A5A5; be = ~b;
    lat = 1;
    while (!ready && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (ready) begin
      rd = rdata;
      e  = err;
      @(posedge clk); #1;
      check_eq("ready_one_cycle", {31'd0, ready}, 32'd0);
    end else begin
      rd  = 32'hXXXX_XXXX;
      e   = 1'bx;
      lat = -1;
    end
  endtask

  logic [31:0] rd;
  logic        e;
  int          lat;
  int          first_p, second_p, npulse;

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_ready", {31'd0, ready}, 32'd0);
    check_eq("reset_err",   {31'd0, err},   32'd0);
    check_eq("reset_rdata", rdata,          32'd0);
    @(negedge clk); reset = 1'b1;

    // Store then read back
    do_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, e, lat);
    check_eq("wr10_lat",   lat,        32'd3);
    check_eq("wr10_err",   {31'd0, e}, 32'd0);
    check_eq("wr10_rdata", rd,         32'd0);
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
    check_eq("rd10_lat",   lat,        32'd3);
    check_eq("rd10_err",   {31'd0, e}, 32'd0);
    check_eq("rd10_rdata", rd,         32'hDEAD_BEEF);
    do_txn(1'b1, 32'h14, 32'h1234_5678, 4'hF, rd, e, lat);
    check_eq("wr14_err",   {31'd0, e}, 32'd0);
    do_txn(1'b0, 32'h14, 32'h0, 4'h0, rd, e, lat);
    check_eq("rd14_rdata", rd,         32'h1234_5678);

    // Error responses
    do_txn(1'b1, 32'h11, 32'h0BAD_0BAD, 4'hF, rd, e, lat);
    check_eq("wr11_err",   {31'd0, e}, 32'd1);
    check_eq("wr11_lat",   lat,        32'd3);
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
    check_eq("rd10_after_err", rd,     32'hDEAD_BEEF);
    do_txn(1'b0, 32'h100, 32'h0, 4'h0, rd, e, lat);
    check_eq("rd100_err",   {31'd0, e}, 32'd1);
    check_eq("rd100_rdata", rd,         32'd0);
    do_txn(1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, e, lat);
    check_eq("rdhi_err",    {31'd0, e}, 32'd1);
    check_eq("rdhi_rdata",  rd,         32'd0);
    do_txn(1'b0, 32'h12, 32'h0, 4'h0, rd, e, lat);
    check_eq("rd12_err",    {31'd0, e}, 32'd1);

    // Back-to-back with req held high: pulses after edges 3, 7, 11
    first_p = 0; second_p = 0; npulse = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h14;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk); #1;
      if (ready) begin
        if (first_p == 0) begin
          first_p = i;
          check_eq("b2b_rdata", rdata, 32'h1234_5678);
        end else if (second_p == 0) begin
          second_p = i;
        end
        npulse++;
      end
    end
    @(negedge clk); req = 1'b0;
    repeat (6) @(posedge clk);
    check_eq("b2b_first",  first_p,            32'd3);
    check_eq("b2b_gap",    second_p - first_p, 32'd4);
    check_eq("b2b_npulse", npulse,             32'd3);

    // Reset during WAIT aborts the store
    do_txn(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, rd, e, lat);
    check_eq("wr20_err", {31'd0, e}, 32'd0);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h0BAD_BEEF; be = 4'hF;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk); reset = 1'b0;
    #1;
    check_eq("midrst_ready", {31'd0, ready}, 32'd0);
    @(posedge clk);
    @(negedge clk); reset = 1'b1;
    npulse = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ready) npulse++;
    end
    check_eq("midrst_no_ready", npulse, 32'd0);
    do_txn(1'b0, 32'h20, 32'h0, 4'h0, rd, e, lat);
    check_eq("rd20_old", rd, 32'hCAFE_F00D);

`ifdef MEM_BYTE_WRITE_EN
    do_txn(1'b1, 32'h30, 32'h1122_3344, 4'hF, rd, e, lat);
    do_txn(1'b1, 32'h30, 32'hAABB_CCDD, 4'b0101, rd, e, lat);
    check_eq("be_wr_err", {31'd0, e}, 32'd0);
    do_txn(1'b0, 32'h30, 32'h0, 4'h0, rd, e, lat);
    check_eq("be_merge", rd, 32'h11BB_33DD);
    do_txn(1'b1, 32'h30, 32'hFFFF_FFFF, 4'h0, rd, e, lat);
    check_eq("be0_err", {31'd0, e}, 32'd0);
    check_eq("be0_lat", lat, 32'd3);
    do_txn(1'b0, 32'h30, 32'h0, 4'h0, rd, e, lat);
    check_eq("be0_nochange", rd, 32'h11BB_33DD);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
